// File: rtl/d_branch_ctrl.sv
// D-stage branch sequencer: drives the comparator op, stalls D until branch
// operands are final, latches the decision/target and pulses a redirect to F
// once the delay-slot instruction occupies D.
module d_branch_ctrl #(
  parameter int PC_W      = 32,
  parameter int MAX_STALL = 4,
  parameter int CNT_W     = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              D_valid,
  input  logic [3:0]        D_br_op,
  input  logic              D_rs_ready,
  input  logic              D_rt_ready,
  input  logic [PC_W-1:0]   D_pc,
  input  logic [15:0]       D_imm16,
  input  logic [31:0]       D_CMP_result,
  output logic [3:0]        D_CMPop,
  output logic              D_stall,
  output logic              F_redirect,
  output logic [PC_W-1:0]   F_target,
  output logic              br_err,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  taken_cnt
);

  localparam int WC_W = $clog2(MAX_STALL + 1);
  localparam logic [WC_W-1:0] WC_MAX = WC_W'(MAX_STALL);
  localparam logic [WC_W-1:0] WC_ONE = WC_W'(1);

  typedef enum logic [1:0] {IDLE, WAIT, REDIR} state_t;

  state_t           state, next;
  logic             taken_q;
  logic [PC_W-1:0]  target_q;
  logic [WC_W-1:0]  wait_cnt;
  logic             is_br, rdy, decide;
  logic [PC_W-1:0]  target;

  // Only bit 0 of the comparator result carries the condition.
  logic unused_cmp;
  assign unused_cmp = ^D_CMP_result[31:1];

  // Single-operand ops (blez..bgez) only need rs.
  assign is_br  = D_valid && (D_br_op >= 4'd1) && (D_br_op <= 4'd6);
  assign rdy    = D_rs_ready && (D_rt_ready || (D_br_op >= 4'd3));
  assign target = D_pc + PC_W'(4) + {{(PC_W-18){D_imm16[15]}}, D_imm16, 2'b00};

  assign F_target = target_q;

  // Next-state and combinational outputs; everything is forced quiet in reset.
  always_comb begin
    next       = state;
    D_CMPop    = 4'd0;
    D_stall    = 1'b0;
    F_redirect = 1'b0;
    decide     = 1'b0;
    if (!reset) begin
      case (state)
        IDLE: begin
          if (is_br) begin
            if (rdy) begin
              D_CMPop = D_br_op;
              decide  = 1'b1;
              next    = REDIR;
            end else begin
              D_stall = 1'b1;
              next    = WAIT;
            end
          end
        end
        WAIT: begin
          // Op and PC are frozen by the stall, so they still describe the branch.
          if (rdy) begin
            D_CMPop = D_br_op;
            decide  = 1'b1;
            next    = REDIR;
          end else begin
            D_stall = 1'b1;
          end
        end
        REDIR: begin
          F_redirect = taken_q;
          next       = IDLE;
        end
        default: next = IDLE;
      endcase
    end
  end

  // State, decision/target latch, wait timeout, sticky error and statistics.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      taken_q   <= 1'b0;
      target_q  <= '0;
      wait_cnt  <= '0;
      br_err    <= 1'b0;
      stall_cnt <= '0;
      taken_cnt <= '0;
    end else begin
      state <= next;

      // A not-taken decision leaves the previous target visible.
      if (decide) begin
        taken_q <= D_CMP_result[0];
        if (D_CMP_result[0]) target_q <= target;
      end

      // The stall cycle spent in IDLE counts as the first operand-wait cycle,
      // so the error rises after MAX_STALL consecutive stall cycles.
      if (state == IDLE && is_br && !rdy) begin
        wait_cnt <= WC_ONE;
        if (WC_ONE >= WC_MAX) br_err <= 1'b1;
      end else if (state == WAIT && !rdy) begin
        if (wait_cnt < WC_MAX) wait_cnt <= wait_cnt + WC_ONE;
        if (wait_cnt + WC_ONE >= WC_MAX) br_err <= 1'b1;
      end else begin
        wait_cnt <= '0;
      end

      // Branch sitting in the delay slot is flagged and dropped.
      if (state == REDIR && is_br) br_err <= 1'b1;

      if (D_stall && stall_cnt != '1) stall_cnt <= stall_cnt + 1'b1;
      if (F_redirect && taken_cnt != '1) taken_cnt <= taken_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_d_branch_ctrl.sv
// Directed bench for d_branch_ctrl: inputs change on the falling edge and all
// outputs are sampled 1ns later, i.e. within the cycle they describe.
module tb_d_branch_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        D_valid;
  logic [3:0]  D_br_op;
  logic        D_rs_ready, D_rt_ready;
  logic [31:0] D_pc;
  logic [15:0] D_imm16;
  logic [31:0] D_CMP_result;
  logic [3:0]  D_CMPop;
  logic        D_stall, F_redirect, br_err;
  logic [31:0] F_target;
  logic [15:0] stall_cnt, taken_cnt;

  int checks = 0;
  int failures = 0;

  d_branch_ctrl dut (
    .clk(clk), .reset(reset), .D_valid(D_valid), .D_br_op(D_br_op),
    .D_rs_ready(D_rs_ready), .D_rt_ready(D_rt_ready), .D_pc(D_pc),
    .D_imm16(D_imm16), .D_CMP_result(D_CMP_result), .D_CMPop(D_CMPop),
    .D_stall(D_stall), .F_redirect(F_redirect), .F_target(F_target),
    .br_err(br_err), .stall_cnt(stall_cnt), .taken_cnt(taken_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance to the next cycle and apply inputs.
  task automatic drive(input logic v, input logic [3:0] op, input logic rs, input logic rt,
                       input logic [31:0] pc, input logic [15:0] imm, input logic [31:0] cmp);
    @(negedge clk);
    D_valid = v; D_br_op = op; D_rs_ready = rs; D_rt_ready = rt;
    D_pc = pc; D_imm16 = imm; D_CMP_result = cmp;
    #1;
  endtask

  task automatic idle();
    drive(1'b0, 4'd0, 1'b0, 1'b0, 32'h0, 16'h0, 32'h0);
  endtask

  initial begin
    reset = 1'b1;
    D_valid = 0; D_br_op = 0; D_rs_ready = 0; D_rt_ready = 0;
    D_pc = 0; D_imm16 = 0; D_CMP_result = 0;
    repeat (2) @(posedge clk);
    @(negedge clk); reset = 1'b0;
    idle();
    chk("rst_cmpop", 32'(D_CMPop), 0);
    chk("rst_stall", 32'(D_stall), 0);
    chk("rst_redir", 32'(F_redirect), 0);
    chk("rst_target", F_target, 0);
    chk("rst_err", 32'(br_err), 0);
    chk("rst_cnts", {stall_cnt, taken_cnt}, 0);

    // Non-branches: invalid beq, and reserved op 9.
    drive(1'b0, 4'd1, 1'b1, 1'b1, 32'h100, 16'h0, 32'h1);
    chk("inv_cmpop", 32'(D_CMPop), 0);
    drive(1'b1, 4'd9, 1'b0, 1'b0, 32'h100, 16'h0, 32'h1);
    chk("op9_cmpop", 32'(D_CMPop), 0);
    chk("op9_stall", 32'(D_stall), 0);
    idle();
    chk("op9_redir", 32'(F_redirect), 0);

    // 1: beq taken, ready immediately.
    drive(1'b1, 4'd1, 1'b1, 1'b1, 32'h3000, 16'h0004, 32'h1);
    chk("t1_cmpop", 32'(D_CMPop), 1);
    chk("t1_stall", 32'(D_stall), 0);
    chk("t1_redir_early", 32'(F_redirect), 0);
    idle();
    chk("t1_redir", 32'(F_redirect), 1);
    chk("t1_target", F_target, 32'h3014);
    chk("t1_cmpop_redir", 32'(D_CMPop), 0);
    idle();
    chk("t1_redir_off", 32'(F_redirect), 0);
    chk("t1_taken_cnt", 32'(taken_cnt), 1);

    // 2: bltz, rs not ready for 2 cycles, rt ignored.
    drive(1'b1, 4'd5, 1'b0, 1'b0, 32'h4000, 16'hFFFF, 32'h1);
    chk("t2_stall0", 32'(D_stall), 1);
    chk("t2_cmpop0", 32'(D_CMPop), 0);
    drive(1'b1, 4'd5, 1'b0, 1'b0, 32'h4000, 16'hFFFF, 32'h1);
    chk("t2_stall1", 32'(D_stall), 1);
    chk("t2_cmpop1", 32'(D_CMPop), 0);
    drive(1'b1, 4'd5, 1'b1, 1'b0, 32'h4000, 16'hFFFF, 32'h1);
    chk("t2_stall2", 32'(D_stall), 0);
    chk("t2_cmpop2", 32'(D_CMPop), 5);
    idle();
    chk("t2_redir", 32'(F_redirect), 1);
    chk("t2_target", F_target, 32'h4000);
    idle();
    chk("t2_stall_cnt", 32'(stall_cnt), 2);
    chk("t2_err", 32'(br_err), 0);
    chk("t2_taken_cnt", 32'(taken_cnt), 2);

    // 3: bne not taken; upper comparator bits must be ignored.
    drive(1'b1, 4'd2, 1'b1, 1'b1, 32'h5000, 16'h0008, 32'hFFFF_FFFE);
    chk("t3_cmpop", 32'(D_CMPop), 2);
    idle();
    chk("t3_redir", 32'(F_redirect), 0);
    chk("t3_target_kept", F_target, 32'h4000);
    idle();
    chk("t3_taken_cnt", 32'(taken_cnt), 2);

    // 4: bgtz waits past MAX_STALL (4) stall cycles.
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 4'd4, 1'b0, 1'b0, 32'h6000, 16'h0010, 32'h1);
      chk("t4_stall", 32'(D_stall), 1);
      chk("t4_err_before", 32'(br_err), 0);
    end
    drive(1'b1, 4'd4, 1'b0, 1'b0, 32'h6000, 16'h0010, 32'h1);
    chk("t4_err", 32'(br_err), 1);
    chk("t4_stall_held", 32'(D_stall), 1);
    drive(1'b1, 4'd4, 1'b1, 1'b0, 32'h6000, 16'h0010, 32'h1);
    chk("t4_stall_rel", 32'(D_stall), 0);
    chk("t4_cmpop", 32'(D_CMPop), 4);
    idle();
    chk("t4_redir", 32'(F_redirect), 1);
    chk("t4_target", F_target, 32'h6044);
    idle();
    chk("t4_err_sticky", 32'(br_err), 1);
    chk("t4_stall_cnt", 32'(stall_cnt), 7);
    chk("t4_taken_cnt", 32'(taken_cnt), 3);

    // 6a: reset while in WAIT.
    drive(1'b1, 4'd1, 1'b0, 1'b1, 32'h8000, 16'h0001, 32'h1);
    drive(1'b1, 4'd1, 1'b0, 1'b1, 32'h8000, 16'h0001, 32'h1);
    chk("t6_in_wait", 32'(D_stall), 1);
    reset = 1'b1;
    idle();
    reset = 1'b0;
    #1;
    chk("t6_stall", 32'(D_stall), 0);
    chk("t6_redir", 32'(F_redirect), 0);
    chk("t6_target", F_target, 0);
    chk("t6_err", 32'(br_err), 0);
    chk("t6_cnts", {stall_cnt, taken_cnt}, 0);
    idle();
    chk("t6_no_redir", 32'(F_redirect), 0);
    chk("t6_idle_stall", 32'(D_stall), 0);

    // 5: beq taken, bgez in the delay slot.
    drive(1'b1, 4'd1, 1'b1, 1'b1, 32'h7000, 16'h0002, 32'h1);
    chk("t5_cmpop", 32'(D_CMPop), 1);
    drive(1'b1, 4'd6, 1'b1, 1'b1, 32'h7004, 16'h0020, 32'h1);
    chk("t5_redir", 32'(F_redirect), 1);
    chk("t5_target", F_target, 32'h700C);
    chk("t5_slot_cmpop", 32'(D_CMPop), 0);
    idle();
    chk("t5_err", 32'(br_err), 1);
    chk("t5_no_second", 32'(F_redirect), 0);
    idle();
    chk("t5_no_second2", 32'(F_redirect), 0);
    chk("t5_taken_cnt", 32'(taken_cnt), 1);

    // 6b: target wraps modulo 2^32.
    drive(1'b1, 4'd1, 1'b1, 1'b1, 32'hFFFF_FFF8, 16'h0001, 32'h1);
    idle();
    chk("wrap_redir", 32'(F_redirect), 1);
    chk("wrap_target", F_target, 32'h0);
    idle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Hard time bound so the run always ends.
  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
